router_pkt_ingress: RTL and testbench
=====================================

Name: router_pkt_ingress

Overview:
- Ingress stage of the 1x3 router, directly upstream of the three router_fifo instances.
- Parses the incoming byte stream `{len[5:0], addr[1:0]}` header, payload, parity, and steers every byte to the addressed FIFO.
- Generates lfd_state for the header byte, back-pressures the source with busy, and checks packet parity and length.

Parameters:
- DATA_W, 8, byte width of the data path.
- N_PORTS, 3, number of destination FIFOs; addr values >= N_PORTS are invalid.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- data_in  in  DATA_W  source byte: header, then payload, then parity.
- pkt_valid  in  1  high from the header through the last payload byte; the parity byte is presented in the first cycle with pkt_valid=0.
- fifo_full  in  N_PORTS  full flags from the FIFOs.
- fifo_empty  in  N_PORTS  empty flags from the FIFOs.
- dout  out  DATA_W  byte to the FIFOs (shared bus).
- write_enb  out  N_PORTS  one-hot write strobe to the addressed FIFO.
- lfd_state  out  1  high in the cycle the header is written.
- busy  out  1  source must hold data_in stable while high.
- parity_done  out  1  one-cycle pulse when the packet's parity check completes.
- err  out  1  parity mismatch of the last packet; held until the next header.
- len_err  out  1  payload count != header len; held until the next header.

Behaviour:
- Handshake: a byte is consumed on a rising edge where the state accepts input and busy=0. Otherwise the source holds the byte.
- Data path is combinational: dout = data_in, or hdr_reg during LOAD_FIRST. write_enb/lfd_state are combinational from the registered state plus fifo_full. This gives zero-cycle data latency into the FIFO.
- Reset (rst=1 at an edge):
  - state <- IDLE.
  - hdr_reg, addr_reg, int_parity, byte count <- 0.
  - err, len_err, parity_done <- 0.
  - pkt_valid_d <- 1, so a packet in flight during reset is ignored until pkt_valid drops.
  - Combinational outputs (dout, write_enb, lfd_state, busy) are 0 while rst=1.
- pkt_valid_d is a registered copy of pkt_valid. A header is recognised only when pkt_valid=1 and pkt_valid_d=0.
- FSM states:
  - IDLE, busy=0:
    - On a header edge with addr < N_PORTS: capture hdr_reg and addr_reg, clear err and len_err, set int_parity=header, clear count.
    - Then go to LOAD_FIRST if fifo_empty[addr]=1, else WAIT_EMPTY.
    - addr=3: go to DROP.
  - WAIT_EMPTY, busy=1: stay until fifo_empty[addr_reg]=1, then go to LOAD_FIRST.
  - LOAD_FIRST, busy=1: dout=hdr_reg, write_enb[addr_reg]=1, lfd_state=1. Go to LOAD_DATA.
  - LOAD_DATA:
    - busy = fifo_full[addr_reg].
    - If pkt_valid=1 and not full: write data_in, int_parity ^= data_in, count += 1 (saturating at 63).
    - If pkt_valid=0 and not full: write data_in as the parity byte, latch parity_ok = (data_in == int_parity), go to CHECK.
    - If full: no write, stay in LOAD_DATA.
  - CHECK, busy=1: parity_done=1 for this cycle, err <= !parity_ok, len_err <= (count != hdr_reg[7:2]). Go to IDLE.
  - DROP, busy=0: consume and discard bytes; no writes. Return to IDLE the cycle after pkt_valid=0 (the parity byte is also dropped).
- Boundaries:
  - len=0 header: the parity byte directly follows the header; len_err=0 if no payload was sent.
  - FIFO full on the parity byte: stall in LOAD_DATA until it is written.
  - A new header edge during LOAD_DATA is impossible because pkt_valid never rises while already high. pkt_valid rising in CHECK is held off, since busy=1.
  - write_enb is never multi-hot; at most one bit is set in any cycle.

Decomposition:
- router_pkg holds:
  - the state enum {IDLE, WAIT_EMPTY, LOAD_FIRST, LOAD_DATA, CHECK, DROP};
  - header field positions (LEN_MSB=7, LEN_LSB=2, ADDR_MSB=1);
  - N_PORTS and DATA_W.
- One sub-module, router_ingress_fsm: next-state logic and busy/lfd decode. Parity, count and header registers stay in the top.

Test Plan:
- Reset, then header 8'h3A (len=14, addr=2) with fifo_empty=3'b111:
  - header written with write_enb=3'b100 and lfd_state=1 in LOAD_FIRST;
  - 14 payload bytes, then parity = XOR of all bytes;
  - parity_done pulses once, err=0, len_err=0.
- Same packet with a corrupted parity byte: err=1 after CHECK, and err clears at the next header.
- Header addr=1 while fifo_empty[1]=0 for 5 cycles: busy=1, no writes for 5 cycles, then LOAD_FIRST writes 8'h?5 to port 1.
- Force fifo_full[addr] high for 3 cycles mid-payload: busy=1 and write_enb=0 for exactly those cycles; no byte is lost or duplicated (scoreboard check).
- Header 8'h0B (addr=3): no write_enb for the whole packet, busy=0 throughout, FSM back in IDLE one cycle after pkt_valid=0.
- Assert rst for 1 cycle mid-payload with pkt_valid still high: no writes until pkt_valid drops and a fresh header arrives; err, len_err and parity_done read 0.

Source files
------------

// File: rtl/router_pkg.sv
// Shared types and header field layout for the router ingress stage.
package router_pkg;
  localparam int DATA_W  = 8;
  localparam int N_PORTS = 3;

  localparam int LEN_MSB  = 7;
  localparam int LEN_LSB  = 2;
  localparam int ADDR_MSB = 1;
  localparam int LEN_W    = LEN_MSB - LEN_LSB + 1;
  localparam int ADDR_W   = ADDR_MSB + 1;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_EMPTY,
    LOAD_FIRST,
    LOAD_DATA,
    CHECK,
    DROP
  } state_e;

  function automatic logic addr_ok(input logic [ADDR_W-1:0] addr);
    return {{(32-ADDR_W){1'b0}}, addr} < N_PORTS;
  endfunction
endpackage

// File: rtl/router_pkt_ingress_if.sv
// Source-side byte stream plus FIFO-side write bus of the router ingress stage.
interface router_pkt_ingress_if;
  import router_pkg::*;

  logic [DATA_W-1:0]  data_in;
  logic               pkt_valid;
  logic [N_PORTS-1:0] fifo_full;
  logic [N_PORTS-1:0] fifo_empty;
  logic [DATA_W-1:0]  dout;
  logic [N_PORTS-1:0] write_enb;
  logic               lfd_state;
  logic               busy;
  logic               parity_done;
  logic               err;
  logic               len_err;

  modport master (
    output data_in, pkt_valid, fifo_full, fifo_empty,
    input  dout, write_enb, lfd_state, busy, parity_done, err, len_err
  );

  modport slave (
    input  data_in, pkt_valid, fifo_full, fifo_empty,
    output dout, write_enb, lfd_state, busy, parity_done, err, len_err
  );
endinterface

// File: rtl/router_ingress_fsm.sv
// Packet-framing state machine: next-state logic plus busy/lfd_state decode.
module router_ingress_fsm
  import router_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   hdr_edge,
  input  logic   hdr_addr_ok,
  input  logic   hdr_dst_empty,
  input  logic   dst_empty,
  input  logic   dst_full,
  input  logic   pkt_valid,
  output state_e state_q,
  output logic   busy,
  output logic   lfd_state
);
  state_e state_d;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    busy      = 1'b0;
    lfd_state = 1'b0;
    case (state_q)
      IDLE: begin
        if (hdr_edge) begin
          if (!hdr_addr_ok)       state_d = DROP;
          else if (hdr_dst_empty) state_d = LOAD_FIRST;
          else                    state_d = WAIT_EMPTY;
        end
      end
      WAIT_EMPTY: begin
        busy = 1'b1;
        if (dst_empty) state_d = LOAD_FIRST;
      end
      LOAD_FIRST: begin
        busy      = 1'b1;
        lfd_state = 1'b1;
        state_d   = LOAD_DATA;
      end
      LOAD_DATA: begin
        // pkt_valid low marks the parity byte; it still has to land in the FIFO
        busy = dst_full;
        if (!dst_full && !pkt_valid) state_d = CHECK;
      end
      CHECK: begin
        busy    = 1'b1;
        state_d = IDLE;
      end
      DROP: begin
        if (!pkt_valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (rst) begin
      busy      = 1'b0;
      lfd_state = 1'b0;
    end
  end
endmodule

// File: rtl/router_pkt_ingress.sv
// Router ingress: parses header/payload/parity and steers each byte to the addressed FIFO.
module router_pkt_ingress
  import router_pkg::*;
(
  input logic                 clk,
  input logic                 rst,
  router_pkt_ingress_if.slave bus
);
  state_e              state_q;
  logic                busy;
  logic                lfd_state;
  logic [DATA_W-1:0]   hdr_q, hdr_d;
  logic [DATA_W-1:0]   parity_q, parity_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LEN_W-1:0]    count_q, count_d;
  logic                pkt_valid_d_q, pkt_valid_d_d;
  logic                err_q, err_d;
  logic                len_err_q, len_err_d;
  logic                parity_done_q, parity_done_d;
  logic                parity_ok_q, parity_ok_d;
  logic [ADDR_W-1:0]   hdr_addr;
  logic                hdr_edge, hdr_addr_ok, hdr_dst_empty;
  logic                dst_full, dst_empty;
  logic [N_PORTS-1:0]  sel;

  assign hdr_addr      = bus.data_in[ADDR_MSB:0];
  assign hdr_edge      = bus.pkt_valid & ~pkt_valid_d_q;
  assign hdr_addr_ok   = addr_ok(hdr_addr);
  assign hdr_dst_empty = hdr_addr_ok & bus.fifo_empty[hdr_addr];
  assign dst_full      = bus.fifo_full[addr_q];
  assign dst_empty     = bus.fifo_empty[addr_q];
  assign sel           = N_PORTS'(1) << addr_q;

  router_ingress_fsm u_fsm (
    .clk           (clk),
    .rst           (rst),
    .hdr_edge      (hdr_edge),
    .hdr_addr_ok   (hdr_addr_ok),
    .hdr_dst_empty (hdr_dst_empty),
    .dst_empty     (dst_empty),
    .dst_full      (dst_full),
    .pkt_valid     (bus.pkt_valid),
    .state_q       (state_q),
    .busy          (busy),
    .lfd_state     (lfd_state)
  );

  always_comb begin
    hdr_d         = hdr_q;
    parity_d      = parity_q;
    addr_d        = addr_q;
    count_d       = count_q;
    pkt_valid_d_d = bus.pkt_valid;
    err_d         = err_q;
    len_err_d     = len_err_q;
    parity_ok_d   = parity_ok_q;
    parity_done_d = 1'b0;
    bus.dout      = bus.data_in;
    bus.write_enb = '0;
    case (state_q)
      IDLE: begin
        if (hdr_edge && hdr_addr_ok) begin
          hdr_d     = bus.data_in;
          addr_d    = hdr_addr;
          parity_d  = bus.data_in;
          count_d   = '0;
          err_d     = 1'b0;
          len_err_d = 1'b0;
        end
      end
      LOAD_FIRST: begin
        bus.dout      = hdr_q;
        bus.write_enb = sel;
      end
      LOAD_DATA: begin
        if (!dst_full) begin
          bus.write_enb = sel;
          if (bus.pkt_valid) begin
            parity_d = parity_q ^ bus.data_in;
            if (count_q != '1) count_d = count_q + LEN_W'(1);
          end else begin
            parity_ok_d   = (bus.data_in == parity_q);
            parity_done_d = 1'b1;
          end
        end
      end
      CHECK: begin
        err_d     = ~parity_ok_q;
        len_err_d = (count_q != hdr_q[LEN_MSB:LEN_LSB]);
      end
      default: ;
    endcase
    if (rst) begin
      bus.dout      = '0;
      bus.write_enb = '0;
    end
  end

  // A packet already in flight when reset lifts is ignored until pkt_valid drops
  always_ff @(posedge clk) begin
    if (rst) begin
      hdr_q         <= '0;
      parity_q      <= '0;
      addr_q        <= '0;
      count_q       <= '0;
      pkt_valid_d_q <= 1'b1;
      err_q         <= 1'b0;
      len_err_q     <= 1'b0;
      parity_done_q <= 1'b0;
      parity_ok_q   <= 1'b0;
    end else begin
      hdr_q         <= hdr_d;
      parity_q      <= parity_d;
      addr_q        <= addr_d;
      count_q       <= count_d;
      pkt_valid_d_q <= pkt_valid_d_d;
      err_q         <= err_d;
      len_err_q     <= len_err_d;
      parity_done_q <= parity_done_d;
      parity_ok_q   <= parity_ok_d;
    end
  end

  assign bus.busy        = busy;
  assign bus.lfd_state   = lfd_state;
  assign bus.parity_done = parity_done_q;
  assign bus.err         = err_q;
  assign bus.len_err     = len_err_q;
endmodule

// File: tb/tb_router_pkt_ingress.sv
// Scoreboard bench for router_pkt_ingress: directed packets, FIFO writes checked by a monitor.
module tb_router_pkt_ingress;
  logic clk = 1'b0;
  logic rst;

  router_pkt_ingress_if bus ();

  router_pkt_ingress dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] port;
    logic [7:0] data;
    logic       lfd;
  } exp_t;

  exp_t q[$];
  int   tests  = 0;
  int   fails  = 0;
  int   pulses = 0;
  int   full_left  = 0;
  int   empty_left = 0;
  logic [2:0] full_mask  = 3'b000;
  logic [2:0] empty_mask = 3'b000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] pay(input logic [7:0] hdr, input int i);
    return hdr ^ 8'(i * 37 + 5);
  endfunction

  // Monitor: every FIFO write must match the next expected byte
  always begin
    exp_t e;
    @(negedge clk);
    #2;
    if (bus.parity_done === 1'b1) pulses++;
    if (bus.write_enb !== 3'b000) begin
      if (q.size() == 0) begin
        chk("unexpected_write", {29'd0, bus.write_enb}, 32'd0);
      end else begin
        e = q.pop_front();
        chk("wr_port", {29'd0, bus.write_enb}, {29'd0, 3'b001 << e.port});
        chk("wr_data", {24'd0, bus.dout}, {24'd0, e.data});
        chk("wr_lfd", {31'd0, bus.lfd_state}, {31'd0, e.lfd});
      end
    end
  end

  // Presents one byte starting at a falling edge; returns how many edges it was held off
  task automatic send(input logic [7:0] b, input logic v, output int stalls);
    logic stalled;
    stalls = 0;
    bus.data_in   = b;
    bus.pkt_valid = v;
    forever begin
      bus.fifo_full  = (full_left > 0) ? full_mask : 3'b000;
      if (full_left > 0) full_left--;
      bus.fifo_empty = (empty_left > 0) ? ~empty_mask : 3'b111;
      if (empty_left > 0) empty_left--;
      #1;
      stalled = bus.busy;
      @(posedge clk);
      @(negedge clk);
      if (!stalled) break;
      stalls++;
      if (stalls > 100) begin
        chk("send_timeout", 32'(stalls), 32'd0);
        break;
      end
    end
  endtask

  task automatic send_pkt(input logic [7:0] hdr, input int n, input logic bad_par,
                          input int full_at, input int full_n, input int par_full,
                          input int first_stall, input logic exp_len_err);
    logic [1:0] port;
    logic       ok;
    logic [7:0] par, b;
    int         st, exp_st;
    port = hdr[1:0];
    ok   = (port != 2'd3);
    par  = hdr;
    if (ok) q.push_back('{port, hdr, 1'b1});
    send(hdr, 1'b1, st);
    chk("hdr_stall", 32'(st), 32'd0);
    if (ok) begin
      chk("hdr_clears_err", {31'd0, bus.err}, 32'd0);
      chk("hdr_clears_len_err", {31'd0, bus.len_err}, 32'd0);
    end
    for (int i = 0; i < n; i++) begin
      b   = pay(hdr, i);
      par = par ^ b;
      if (ok) q.push_back('{port, b, 1'b0});
      exp_st = 0;
      if (ok && i == 0) exp_st = first_stall;
      if (ok && i == full_at) begin
        full_mask = 3'b001 << port;
        full_left = full_n;
        exp_st    = exp_st + full_n;
      end
      send(b, 1'b1, st);
      chk("payload_stall", 32'(st), 32'(exp_st));
    end
    b = bad_par ? (par ^ 8'h01) : par;
    if (ok) q.push_back('{port, b, 1'b0});
    exp_st = (ok && n == 0) ? first_stall : 0;
    if (ok && par_full > 0) begin
      full_mask = 3'b001 << port;
      full_left = par_full;
      exp_st    = exp_st + par_full;
    end
    send(b, 1'b0, st);
    chk("parity_stall", 32'(st), 32'(exp_st));
    if (ok) begin
      bus.data_in   = 8'h00;
      bus.pkt_valid = 1'b0;
      #1;
      chk("parity_done_high", {31'd0, bus.parity_done}, 32'd1);
      chk("busy_in_check", {31'd0, bus.busy}, 32'd1);
      @(negedge clk);
      #1;
      chk("parity_done_low", {31'd0, bus.parity_done}, 32'd0);
      chk("err", {31'd0, bus.err}, {31'd0, bad_par});
      chk("len_err", {31'd0, bus.len_err}, {31'd0, exp_len_err});
      @(negedge clk);
    end
  endtask

  initial begin
    int st;
    rst            = 1'b1;
    bus.data_in    = 8'h00;
    bus.pkt_valid  = 1'b0;
    bus.fifo_full  = 3'b000;
    bus.fifo_empty = 3'b111;
    repeat (2) @(negedge clk);
    bus.data_in   = 8'h3A;
    bus.pkt_valid = 1'b1;
    #1;
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_write_enb", {29'd0, bus.write_enb}, 32'd0);
    chk("rst_lfd", {31'd0, bus.lfd_state}, 32'd0);
    chk("rst_dout", {24'd0, bus.dout}, 32'd0);
    @(negedge clk);
    bus.pkt_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_err", {31'd0, bus.err}, 32'd0);
    chk("rst_len_err", {31'd0, bus.len_err}, 32'd0);
    chk("rst_parity_done", {31'd0, bus.parity_done}, 32'd0);
    @(negedge clk);

    // len=14 to port 2, clean
    send_pkt(8'h3A, 14, 1'b0, -1, 0, 0, 1, 1'b0);
    // same packet, corrupted parity, parity byte held off by a full FIFO
    send_pkt(8'h3A, 14, 1'b1, -1, 0, 2, 1, 1'b0);
    // port 1 not empty for 5 cycles: 5 wait cycles plus LOAD_FIRST
    empty_mask = 3'b010;
    empty_left = 5;
    send_pkt(8'h15, 5, 1'b0, -1, 0, 0, 6, 1'b0);
    // FIFO 2 full for 3 cycles mid-payload
    send_pkt(8'h3A, 14, 1'b0, 6, 3, 0, 1, 1'b0);
    // addr=3 dropped, then a len=0 packet right behind it
    send_pkt(8'h0B, 2, 1'b0, -1, 0, 0, 0, 1'b0);
    send_pkt(8'h00, 0, 1'b0, -1, 0, 0, 1, 1'b0);
    // short payload: 13 bytes for len=14
    send_pkt(8'h3A, 13, 1'b0, -1, 0, 0, 1, 1'b1);

    // reset mid-payload with pkt_valid still high
    q.push_back('{2'd2, 8'h3A, 1'b1});
    send(8'h3A, 1'b1, st);
    for (int i = 0; i < 4; i++) begin
      q.push_back('{2'd2, pay(8'h3A, i), 1'b0});
      send(pay(8'h3A, i), 1'b1, st);
    end
    rst           = 1'b1;
    bus.data_in   = 8'h55;
    #1;
    chk("midrst_write_enb", {29'd0, bus.write_enb}, 32'd0);
    chk("midrst_busy", {31'd0, bus.busy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      send(8'h81 + 8'(i), 1'b1, st);
      chk("postrst_stall", 32'(st), 32'd0);
    end
    send(8'hC3, 1'b0, st);
    #1;
    chk("postrst_err", {31'd0, bus.err}, 32'd0);
    chk("postrst_len_err", {31'd0, bus.len_err}, 32'd0);
    chk("postrst_parity_done", {31'd0, bus.parity_done}, 32'd0);
    @(negedge clk);
    send_pkt(8'h15, 5, 1'b0, -1, 0, 0, 1, 1'b0);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    chk("parity_done_pulses", 32'(pulses), 32'd7);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
